mon_sopc_ram_bist: RTL
======================

# mon_sopc_ram_bist

Avalon-MM master engine that writes a deterministic pattern into a word-addressed on-chip RAM slave and reads it back to check it.

- Sits beside the system's on-chip RAM as a second master on the SOPC interconnect.
- Used for power-on memory test and scrubbing.
- Reports pass/fail, a saturating error count and the first failing word address.

## Interface
Parameters:
- ADDR_W, 13: word-address width; matches the 13-bit RAM slave.
- DATA_W, 32: data width. Byteenable is DATA_W/8 bits, always all-ones.
- CNT_W, 14: width of word count; 8192 words must be expressible.
- MAX_PENDING, 4: maximum outstanding reads (1..15).

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle pulse; sampled only in IDLE.
- base_addr, in, ADDR_W: first word address.
- word_count, in, CNT_W: number of words to test.
- seed, in, DATA_W: pattern seed.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse at end of test.
- pass, out, 1: valid from done until the next accepted start.
- err_count, out, 16: mismatch count, saturates at 0xFFFF.
- first_fail_addr, out, ADDR_W: address of the first mismatch.
- avm_address, out, ADDR_W.
- avm_byteenable, out, DATA_W/8.
- avm_read, out, 1.
- avm_write, out, 1.
- avm_writedata, out, DATA_W.
- avm_readdata, in, DATA_W.
- avm_waitrequest, in, 1.
- avm_readdatavalid, in, 1.

## Operation
- Expected data for word i (0-based): P(i) = seed + i, 32-bit modulo add.
- Address for word i: (base_addr + i) mod 2^ADDR_W; wraps past 0x1FFF to 0x0000.
- States:
  - IDLE: start with word_count ≠ 0 → WRITE, counters cleared. start with word_count = 0 → done pulse with pass=1, err_count=0, no bus traffic.
  - WRITE: issues one write per accepted transfer. Last write accepted → READ.
  - READ: issues reads while outstanding < MAX_PENDING. Last read accepted → DRAIN.
  - DRAIN: waits until outstanding = 0 → DONE.
  - DONE: pulses done for one cycle → IDLE.
- Response tracking: a separate response index increments on each avm_readdatavalid. On mismatch:
  - err_count increments (saturating).
  - first_fail_addr is latched only on the first mismatch of the run.
- Outstanding counter: +1 on read accept, −1 on readdatavalid. On simultaneous accept and readdatavalid it stays unchanged.
- pass = (err_count == 0) at DONE.
- start while busy is ignored. base_addr, word_count and seed are latched at the accepted start.
- readdatavalid seen in IDLE is ignored and does not affect counters.
- Reset mid-operation: returns to IDLE next cycle and drops all outstanding reads; responses still in flight are ignored.
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=all-ones, busy=0, done=0, pass=0, err_count=0, first_fail_addr=0.

## Timing
- Transfer accepted in a cycle where avm_read or avm_write is high and avm_waitrequest is low.
- While waitrequest is high, address, writedata and command are held stable.
- All outputs are registered.
- start accepted in cycle 0; busy=1 from cycle 1.
- Zero wait states, RAM read latency 1, word count N, macro off:
  - writes occupy cycles 1..N;
  - reads occupy cycles N+1..2N;
  - last readdatavalid arrives at cycle 2N+1;
  - done=1 at cycle 2N+2;
  - busy falls with done, so busy=0 from cycle 2N+3.
- Back-to-back: a new start is accepted in the first IDLE cycle after done.

## Configuration
- MEM_BIST_INVERT_PASS_EN:
  - Defined: after the first DRAIN, the block runs a second WRITE/READ/DRAIN pass over the same range with data ~P(i). Errors accumulate across both passes. first_fail_addr holds the earliest mismatch in time. With zero waits, done lands at cycle 4N+3.
  - Undefined: a single pass only; the second-pass logic is absent.

## Test plan
- Clean RAM model, base 0x0000, N=16, seed 0xA5A50000, zero waits.
  - Writes 0xA5A50000..0xA5A5000F.
  - done at cycle 34, pass=1, err_count=0.
- RAM model forcing bit 3 stuck-at-1 at address 0x0005.
  - pass=0, err_count=1, first_fail_addr=0x0005.
- Wrap-around: base 0x1FFE, N=4.
  - Addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 are written and read in that order.
- Random waitrequest (50%) and readdatavalid latency 3, MAX_PENDING=4, N=64.
  - Outstanding never exceeds 4.
  - Commands stay stable under waitrequest.
  - pass=1.
- word_count=0 → done one cycle after start, pass=1, no avm_read or avm_write.
- Reset asserted mid-READ with 2 reads outstanding.
  - Next cycle: IDLE, busy=0, avm_read=0.
  - Late readdatavalid does not change err_count.
  - A subsequent N=8 run passes.

Source files
------------

// File: rtl/mon_sopc_ram_bist.sv
// Avalon-MM BIST master: writes seed+i over a word range, reads it back and counts mismatches.
// Define MEM_BIST_INVERT_PASS_EN to add a second pass using inverted data ~(seed+i).
module mon_sopc_ram_bist #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CNT_W       = 14,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_fail_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    localparam int unsigned OUT_W = 4;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_PENDING);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] seed_q;
    logic [CNT_W-1:0]  cmd_idx_q;
    logic [CNT_W-1:0]  rsp_idx_q;
    logic [OUT_W-1:0]  outstanding_q;

`ifdef MEM_BIST_INVERT_PASS_EN
    logic phase_q;
`else
    logic phase_q;
    assign phase_q = 1'b0;
`endif

    logic [CNT_W-1:0]  last_idx;
    logic              wr_accept;
    logic              rd_accept;
    logic              rsp_valid;
    logic              mismatch;
    logic [DATA_W-1:0] expected;
    logic [OUT_W-1:0]  outstanding_d;
    logic [15:0]       err_count_d;

    assign avm_byteenable = '1;

    always_comb begin
        last_idx  = count_q - CNT_W'(1);
        wr_accept = avm_write & ~avm_waitrequest;
        rd_accept = avm_read & ~avm_waitrequest;
        // Responses only count while reads of this run can be in flight.
        rsp_valid = avm_readdatavalid && (outstanding_q != '0) &&
                    (state_q == StRead || state_q == StDrain);
        expected  = seed_q + DATA_W'(rsp_idx_q);
        if (phase_q) begin
            expected = ~expected;
        end
        mismatch = rsp_valid && (avm_readdata != expected);

        outstanding_d = outstanding_q;
        if (rd_accept && !rsp_valid) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!rd_accept && rsp_valid) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        err_count_d = err_count;
        if (mismatch && err_count != 16'hFFFF) begin
            err_count_d = err_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            base_q          <= '0;
            count_q         <= '0;
            seed_q          <= '0;
            cmd_idx_q       <= '0;
            rsp_idx_q       <= '0;
            outstanding_q   <= '0;
`ifdef MEM_BIST_INVERT_PASS_EN
            phase_q         <= 1'b0;
`endif
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            avm_address     <= '0;
            avm_read        <= 1'b0;
            avm_write       <= 1'b0;
            avm_writedata   <= '0;
        end else begin
            done          <= 1'b0;
            outstanding_q <= outstanding_d;

            if (rsp_valid) begin
                rsp_idx_q <= rsp_idx_q + CNT_W'(1);
            end
            if (mismatch) begin
                err_count <= err_count_d;
                if (err_count == '0) begin
                    first_fail_addr <= base_q + ADDR_W'(rsp_idx_q);
                end
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q          <= base_addr;
                        count_q         <= word_count;
                        seed_q          <= seed;
                        cmd_idx_q       <= '0;
                        rsp_idx_q       <= '0;
                        outstanding_q   <= '0;
`ifdef MEM_BIST_INVERT_PASS_EN
                        phase_q         <= 1'b0;
`endif
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        busy            <= 1'b1;
                        if (word_count == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            state_q       <= StWrite;
                            pass          <= 1'b0;
                            avm_write     <= 1'b1;
                            avm_address   <= base_addr;
                            avm_writedata <= seed;
                        end
                    end
                end

                StWrite: begin
                    if (wr_accept) begin
                        if (cmd_idx_q == last_idx) begin
                            state_q     <= StRead;
                            cmd_idx_q   <= '0;
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= base_q;
                        end else begin
                            cmd_idx_q   <= cmd_idx_q + CNT_W'(1);
                            avm_address <= avm_address + ADDR_W'(1);
                            // ~(s+i+1) == ~(s+i) - 1, so the inverted pass counts down.
                            avm_writedata <= phase_q ? avm_writedata - DATA_W'(1)
                                                     : avm_writedata + DATA_W'(1);
                        end
                    end
                end

                StRead: begin
                    if (rd_accept) begin
                        if (cmd_idx_q == last_idx) begin
                            state_q  <= StDrain;
                            avm_read <= 1'b0;
                        end else begin
                            cmd_idx_q   <= cmd_idx_q + CNT_W'(1);
                            avm_address <= avm_address + ADDR_W'(1);
                            avm_read    <= (outstanding_d < MAX_OUT);
                        end
                    end else if (!avm_read) begin
                        avm_read <= (outstanding_d < MAX_OUT);
                    end
                end

                StDrain: begin
                    if (outstanding_d == '0) begin
`ifdef MEM_BIST_INVERT_PASS_EN
                        if (!phase_q) begin
                            phase_q       <= 1'b1;
                            state_q       <= StWrite;
                            cmd_idx_q     <= '0;
                            rsp_idx_q     <= '0;
                            avm_write     <= 1'b1;
                            avm_address   <= base_q;
                            avm_writedata <= ~seed_q;
                        end else begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            pass    <= (err_count_d == '0);
                        end
`else
                        state_q <= StDone;
                        done    <= 1'b1;
                        pass    <= (err_count_d == '0);
`endif
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
